// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : N-operand forwarding select and load-use stall unit with a shadow
//            writer pipeline; FWD_STATS_EN builds the stall-cycle counter.
// Revision : 1.0
// ============================================================================
module fwd_hazard_unit #(
  parameter  int REG_AW     = 5,
  parameter  int NUM_SRC    = 2,
  parameter  int FWD_DEPTH  = 2,
  parameter  int LOAD_STAGE = 2,
  localparam int SELW       = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      flush,
  output logic                      id_stall,
  output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel,
  output logic [31:0]               stall_count
);

  // Slot 0 is EX, slot k is the k-th stage after EX.
  logic [FWD_DEPTH:0]        r_valid;
  logic [FWD_DEPTH:0]        r_regwrite;
  logic [FWD_DEPTH:0]        r_memread;
  logic [REG_AW-1:0]         r_rd [0:FWD_DEPTH];
  logic [NUM_SRC*REG_AW-1:0] r_rs;
  logic [NUM_SRC-1:0]        r_rs_used;

  logic                      w_accept;
  logic [NUM_SRC-1:0]        w_stall_src;

  assign w_accept = id_valid & ~id_stall & ~flush;
  assign id_stall = id_valid & (|w_stall_src);

  function automatic logic is_writer(input logic              v,
                                     input logic              we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] r);
    return v & we & (rd == r) & (r != '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= '0;
      r_regwrite <= '0;
      r_memread  <= '0;
      r_rs       <= '0;
      r_rs_used  <= '0;
      for (int k = 0; k <= FWD_DEPTH; k++) r_rd[k] <= '0;
    end else begin
      r_valid[0]    <= w_accept;
      r_regwrite[0] <= id_regwrite;
      r_memread[0]  <= id_memread;
      r_rd[0]       <= id_rd;
      r_rs          <= id_rs;
      // Bubbles carry no used sources so they never request forwarding.
      r_rs_used     <= id_rs_used & {NUM_SRC{w_accept}};
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        r_valid[k]    <= r_valid[k-1];
        r_regwrite[k] <= r_regwrite[k-1];
        r_memread[k]  <= r_memread[k-1];
        r_rd[k]       <= r_rd[k-1];
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0] w_ex_rs;
    logic [REG_AW-1:0] w_id_rs;
    logic [SELW-1:0]   w_sel;

    assign w_ex_rs = r_rs[i*REG_AW +: REG_AW];
    assign w_id_rs = id_rs[i*REG_AW +: REG_AW];
    assign ex_fwd_sel[i*SELW +: SELW] = w_sel;

    // Scan oldest to youngest so the youngest writer has the last word.
    always_comb begin
      w_sel = '0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (r_rs_used[i] && is_writer(r_valid[k], r_regwrite[k], r_rd[k], w_ex_rs))
          w_sel = SELW'(k);
      end
    end

    always_comb begin
      w_stall_src[i] = 1'b0;
      for (int s = FWD_DEPTH; s >= 0; s--) begin
        if (is_writer(r_valid[s], r_regwrite[s], r_rd[s], w_id_rs))
          w_stall_src[i] = r_memread[s] && ((s + 1) < LOAD_STAGE);
      end
      if (!id_rs_used[i]) w_stall_src[i] = 1'b0;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_count <= '0;
    else if (id_stall && (r_stall_count != 32'hFFFF_FFFF))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'd0;
`endif

endmodule
`default_nettype wire
